// File: rtl/game_pkg.sv
// Shared types and default timing constants for the player-key path.
// Pure declarations, no logic and no latency; no flow control involved.
// Nothing here stalls: constants are consumed at elaboration only.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } keygen_state_t;

    localparam int KEY_HOLD_DEFAULT   = 4;
    localparam int KEY_GAP_DEFAULT    = 2;
    localparam int KEY_QDEPTH_DEFAULT = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired is high for the single cycle the count sits at zero.
// A value N loaded at an edge raises expired N cycles later, so N+1 cycles elapse to the next load.
// No backpressure: a load always wins over counting, clr wins over load.
module cycle_timer #(
    parameter int W = 3
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;
    logic         armed;

    always_ff @(posedge Clock) begin
        if (!Reset_n || clr) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            // Disarm at zero so expired cannot repeat while nobody reloads.
            if (count == '0) begin
                armed <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign expired = armed && (count == '0);

endmodule

// File: rtl/key_press_gen.sv
// Turns one-cycle press requests into HOLD/GAP key waveforms; optional KEY_PRESS_GEN_ABORT_EN adds abort.
// Key rises one edge after an accepted idle request; press period is HOLD_CYCLES+GAP_CYCLES.
// Requests during a press queue up to QDEPTH deep; further requests are dropped silently.
module key_press_gen
    import game_pkg::*;
#(
    parameter int HOLD_CYCLES = KEY_HOLD_DEFAULT,
    parameter int GAP_CYCLES  = KEY_GAP_DEFAULT,
    parameter int QDEPTH      = KEY_QDEPTH_DEFAULT
) (
    input  logic Clock,
    input  logic Reset_n,
`ifdef KEY_PRESS_GEN_ABORT_EN
    input  logic abort,
`endif
    input  logic req,
    output logic key,
    output logic busy,
    output logic full,
    output logic done
);

    localparam int TW = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int PW = $clog2(QDEPTH + 1);

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(QDEPTH);

    keygen_state_t state_q, state_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          tmr_load, tmr_clr, expired;
    logic [TW-1:0] tmr_val;
    logic          done_d;
    logic          start_now;

    cycle_timer #(.W(TW)) u_timer (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (expired)
    );

    assign start_now = req || (pend_q != '0);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        tmr_load = 1'b0;
        tmr_clr  = 1'b0;
        tmr_val  = '0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_now) begin
                    state_d  = PRESS;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                    // A queued start with a coincident request leaves the count unchanged.
                    if (pend_q != '0 && !req) begin
                        pend_d = pend_q - 1'b1;
                    end
                end
            end
            PRESS: begin
                if (req && pend_q != PEND_MAX) begin
                    pend_d = pend_q + 1'b1;
                end
                if (expired) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    done_d   = 1'b1;
                end
            end
            GAP: begin
                if (expired) begin
                    if (start_now) begin
                        state_d  = PRESS;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LOAD;
                        if (pend_q != '0 && !req) begin
                            pend_d = pend_q - 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (req && pend_q != PEND_MAX) begin
                    pend_d = pend_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
                tmr_clr = 1'b1;
            end
        endcase

`ifdef KEY_PRESS_GEN_ABORT_EN
        if (abort) begin
            state_d  = IDLE;
            pend_d   = '0;
            done_d   = 1'b0;
            tmr_load = 1'b0;
            tmr_val  = '0;
            tmr_clr  = 1'b1;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            key     <= 1'b0;
            busy    <= 1'b0;
            full    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            key     <= (state_d == PRESS);
            busy    <= (state_d != IDLE);
            full    <= (pend_d == PEND_MAX);
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_key_press_gen.sv
// Directed and random request patterns checked against a press-schedule model.
module tb_key_press_gen;

    localparam int H = 4;
    localparam int G = 2;
    localparam int Q = 3;
    localparam int P = H + G;

    logic Clock = 1'b0;
    logic Reset_n;
    logic req;
    logic key, busy, full, done;
`ifdef KEY_PRESS_GEN_ABORT_EN
    logic ab_drv = 1'b0;
`endif

    always #5 Clock = ~Clock;

    key_press_gen #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .QDEPTH(Q)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
`ifdef KEY_PRESS_GEN_ABORT_EN
        .abort   (ab_drv),
`endif
        .req     (req),
        .key     (key),
        .busy    (busy),
        .full    (full),
        .done    (done)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int starts[$];
    int last_start = -100;
    int model_presses = 0;
    int rise_cnt = 0, fall_cnt = 0, done_cnt = 0;
    logic key_prev = 1'b0;

    // The model keeps the edge numbers at which each press starts.
    task automatic model_update(input int t, input logic r, input logic clr);
        int  pend;
        bit  qnow;
        if (clr) begin
            starts.delete();
            last_start = -100;
            return;
        end
        while (starts.size() > 0 && starts[0] + P < t) void'(starts.pop_front());
        if (!r) return;
        pend = 0;
        qnow = 0;
        foreach (starts[i]) begin
            if (starts[i] == t) qnow = 1;
            if (starts[i] > t) pend++;
        end
        if (qnow || (pend > 0) || (t < last_start + P)) begin
            if (qnow || pend < Q) begin
                last_start += P;
                starts.push_back(last_start);
                model_presses++;
            end
        end else begin
            last_start = t;
            starts.push_back(t);
            model_presses++;
        end
    endtask

    function automatic logic exp_key(input int e);
        foreach (starts[i]) if (starts[i] <= e && e < starts[i] + H) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_done(input int e);
        foreach (starts[i]) if (e == starts[i] + H) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_busy(input int e);
        foreach (starts[i]) if (starts[i] <= e && e < starts[i] + P) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_full(input int e);
        int n = 0;
        foreach (starts[i]) if (starts[i] > e) n++;
        return (n == Q);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_n, got, exp);
        end
    endtask

    task automatic do_edge(input logic r, input logic rn);
        logic clr;
        req     = r;
        Reset_n = rn;
        @(posedge Clock);
`ifdef KEY_PRESS_GEN_ABORT_EN
        clr = !rn || ab_drv;
`else
        clr = !rn;
`endif
        model_update(edge_n, r, clr);
        #1;
        chk("key",  int'(key),  int'(exp_key(edge_n)));
        chk("done", int'(done), int'(exp_done(edge_n)));
        chk("busy", int'(busy), int'(exp_busy(edge_n)));
        chk("full", int'(full), int'(exp_full(edge_n)));
        if (!key_prev && key) rise_cnt++;
        if (key_prev && !key) fall_cnt++;
        if (done) done_cnt++;
        key_prev = key;
        edge_n++;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) do_edge(1'b0, 1'b1);
    endtask

    task automatic clear_counts;
        rise_cnt = 0;
        fall_cnt = 0;
        done_cnt = 0;
        model_presses = 0;
    endtask

    initial begin
        req     = 1'b0;
        Reset_n = 1'b0;

        // Reset held for two edges, outputs all low afterwards.
        do_edge(1'b0, 1'b0);
        do_edge(1'b0, 1'b0);
        chk("rst_key", int'(key), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_done", int'(done), 0);
        run_idle(3);

        // Single request.
        clear_counts();
        do_edge(1'b1, 1'b1);
        chk("single_rise", int'(key), 1);
        run_idle(12);
        chk("single_presses", rise_cnt, 1);
        chk("single_dones", done_cnt, 1);

        // Four back-to-back requests: one direct, three queued.
        clear_counts();
        for (int i = 0; i < 4; i++) do_edge(1'b1, 1'b1);
        chk("four_full", int'(full), 1);
        run_idle(30);
        chk("four_presses", rise_cnt, 4);
        chk("four_dones", done_cnt, 4);

        // Five requests: the fifth finds the queue full.
        clear_counts();
        for (int i = 0; i < 5; i++) do_edge(1'b1, 1'b1);
        chk("five_full", int'(full), 1);
        run_idle(30);
        chk("five_presses", rise_cnt, 4);
        chk("five_dones", done_cnt, 4);

        // Reset in the middle of a press with one request queued.
        do_edge(1'b1, 1'b1);
        do_edge(1'b1, 1'b1);
        do_edge(1'b0, 1'b0);
        chk("midrst_key", int'(key), 0);
        chk("midrst_done", int'(done), 0);
        clear_counts();
        run_idle(15);
        chk("midrst_presses", rise_cnt, 0);
        chk("midrst_dones", done_cnt, 0);

`ifdef KEY_PRESS_GEN_ABORT_EN
        // Abort with a coincident request after three have queued.
        clear_counts();
        for (int i = 0; i < 4; i++) do_edge(1'b1, 1'b1);
        ab_drv = 1'b1;
        do_edge(1'b1, 1'b1);
        ab_drv = 1'b0;
        chk("abort_key", int'(key), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_full", int'(full), 0);
        clear_counts();
        run_idle(20);
        chk("abort_presses", rise_cnt, 0);
        chk("abort_dones", done_cnt, 0);
`endif

        // Random burst of 20 requests; falling key edges must match done pulses.
        clear_counts();
        for (int n = 0; n < 20; n++) begin
            do_edge(1'b1, 1'b1);
            run_idle(int'($urandom_range(0, 7)));
        end
        run_idle(60);
        chk("loop_fall_vs_done", fall_cnt, done_cnt);
        chk("loop_done_vs_model", done_cnt, model_presses);
        chk("loop_rise_vs_model", rise_cnt, model_presses);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_press_gen.md
# key_press_gen

Synthesizes key-level waveforms from one-cycle press requests: each accepted request becomes one clean press (key high for a fixed hold time) followed by a mandatory release gap. It is the driving end of the player-key path: its `key` output feeds the release-edge detector directly, so the board can be driven by self-test logic or a scripted demo instead of a physical button. Requests arriving during a press are counted and replayed in order, up to a fixed depth.

## Interface
- `HOLD_CYCLES`, default 4: cycles `key` stays high per press; must be ≥1.
- `GAP_CYCLES`, default 2: cycles `key` stays low between presses; must be ≥1.
- `QDEPTH`, default 7: maximum pending (not yet started) requests; must be ≥1.
- `Clock`  in  1  system clock; all logic on its rising edge.
- `Reset_n`  in  1  synchronous, active-low reset.
- `req`  in  1  one-cycle press request.
- `key`  out  1  generated key level, registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `full`  out  1  high when pending == QDEPTH.
- `done`  out  1  one-cycle pulse on the first cycle `key` is low after a press, which is the release edge.

## Operation
- State: `Reset_n` low at an edge forces IDLE, key=0, busy=0, full=0, done=0, pending=0, timer=0.
- States:
  - IDLE: key=0.
  - PRESS: key=1 for HOLD_CYCLES cycles.
  - GAP: key=0 for GAP_CYCLES cycles.
- IDLE → PRESS at an edge where `req`=1 or pending>0.
  - A direct `req` does not touch pending.
  - Otherwise pending decrements.
- PRESS → GAP when the timer expires; `done`=1 for the first GAP cycle only.
- GAP → PRESS if pending>0 or `req`=1 at expiry (same accounting as IDLE). Otherwise GAP → IDLE.
- `req` in PRESS or GAP (not consumed at a transition) increments pending.
  - If pending == QDEPTH, the request is dropped silently and pending stays unchanged.
- A `req` coinciding with a queued start (pending>0): net pending unchanged; the request is queued behind.
- Timer width: $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). Pending width: $clog2(QDEPTH+1). No wrap-around; both saturate by construction.
- Reset mid-press: key falls at that edge, with no `done` and queue cleared.

## Timing
- `req` sampled at edge k in IDLE → key=1 during cycles k+1 … k+HOLD_CYCLES.
- key=0 from edge k+HOLD_CYCLES; `done`=1 during that cycle only.
- Back-to-back presses: next key rise at edge k+HOLD_CYCLES+GAP_CYCLES. Press period = HOLD_CYCLES+GAP_CYCLES.
- busy=1 from edge k through the last GAP cycle; returns to 0 at the edge ending GAP if nothing is pending.
- `full` is registered and reflects pending after the same edge.

## Configuration
- `KEY_PRESS_GEN_ABORT_EN` defined: adds input port `abort` (1 bit), which has priority over everything except reset.
  - `abort`=1 at an edge → IDLE, key=0, pending=0, no `done`.
  - A simultaneous `req` is discarded.
- Undefined: no `abort` port and no abort logic.

## Structure
- Shared package `game_pkg`:
  - typedef enum `keygen_state_t` {IDLE, PRESS, GAP};
  - default constants `KEY_HOLD_DEFAULT`=4, `KEY_GAP_DEFAULT`=2, `KEY_QDEPTH_DEFAULT`=7.
- One sub-module, `cycle_timer`: loadable down-counter with a one-cycle `expired` flag, instantiated once and reloaded on each PRESS/GAP entry.
- The pending counter and FSM live in the top module.

## Test plan
Use HOLD_CYCLES=4, GAP_CYCLES=2, QDEPTH=3 throughout.
- Reset held low 2 cycles, then release → key=0, busy=0, full=0, done=0, pending=0.
- Single `req` at edge 5 → key=1 cycles 6–9, key=0 and done=1 in cycle 10, busy=0 after edge 11.
- Four `req` pulses on consecutive edges 5–8 → first starts directly, three queue, full=1 after edge 8. Key rises at 6, 12, 18, 24; exactly four done pulses, at cycles 10, 16, 22, 28.
- Five `req` pulses on edges 5–9 → fifth dropped (pending stays 3, full stays 1); exactly four presses.
- Reset_n low at edge 7 during PRESS → key=0 from edge 7, no done, pending=0, no further presses.
- With `KEY_PRESS_GEN_ABORT_EN`: 3 queued, `abort` at edge 8 with `req` also high → key=0 and IDLE from edge 8, pending=0, no done, no further presses.
- Loopback: drive the release-edge detector with `key` → its pulse count equals the `done` count over a 20-request random burst.
